// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the processor_arm run-control sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam logic [63:0] DEFAULT_HALT_ADDR = 64'hFF8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over increment) that holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: holds processor_arm in reset, lets it run until timeout or a
// halt store, requests a memory dump, then reports run statistics.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int          N            = 64,
    parameter int          CW           = 16,
    parameter int          RESET_CYCLES = 2,
    parameter int          RUN_CYCLES   = 500,
    parameter int          DUMP_CYCLES  = 2,
    parameter bit          HALT_EN      = 1'b1,
    parameter logic [N-1:0] HALT_ADDR   = N'(DEFAULT_HALT_ADDR)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic          DM_writeEnable,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    output logic          cpu_reset,
    output logic          dump,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] write_count,
    output logic [N-1:0]  last_addr,
    output logic [N-1:0]  last_data
);

    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] DUMP_LAST  = CW'(DUMP_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LIMIT  = CW'(RUN_CYCLES);

    run_state_t    state;
    run_state_t    next_state;
    logic [CW-1:0] phase;
    logic [CW-1:0] cycle_next;
    logic          phase_clr;
    logic          phase_inc;
    logic          stats_clr;
    logic          run_timeout;
    logic          run_store;
    logic          halt_hit;

    assign run_store  = (state == RUN) && DM_writeEnable;
    assign halt_hit   = HALT_EN && run_store && (DM_addr == HALT_ADDR);
    assign cycle_next = cycle_count + CW'(1);

    // One phase counter times both the RESET and DUMP windows; it is cleared on every entry.
    sat_counter #(.W(CW)) phase_ctr (
        .clk   (CLOCK_50),
        .reset (reset),
        .clr   (phase_clr),
        .inc   (phase_inc),
        .count (phase)
    );

    sat_counter #(.W(CW)) write_ctr (
        .clk   (CLOCK_50),
        .reset (reset),
        .clr   (stats_clr),
        .inc   (run_store),
        .count (write_count)
    );

    always_comb begin
        next_state  = state;
        phase_clr   = 1'b0;
        phase_inc   = 1'b0;
        stats_clr   = 1'b0;
        run_timeout = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RESET;
                    phase_clr  = 1'b1;
                    stats_clr  = 1'b1;
                end
            end
            RESET: begin
                if (phase == RESET_LAST) begin
                    next_state = RUN;
                    phase_clr  = 1'b1;
                end else begin
                    phase_inc = 1'b1;
                end
            end
            RUN: begin
                // A halt store on the last allowed cycle still counts as a halt, not a timeout.
                if (halt_hit) begin
                    next_state = DUMP;
                    phase_clr  = 1'b1;
                end else if (cycle_next == RUN_LIMIT) begin
                    next_state  = DUMP;
                    phase_clr   = 1'b1;
                    run_timeout = 1'b1;
                end
            end
            DUMP: begin
                if (phase == DUMP_LAST) begin
                    next_state = DONE;
                end else begin
                    phase_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            dump      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state == IDLE) || (next_state == RESET);
            dump      <= (next_state == DUMP);
            busy      <= (next_state == RESET) || (next_state == RUN) || (next_state == DUMP);
            done      <= (next_state == DONE);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timeout     <= 1'b0;
            cycle_count <= '0;
            last_addr   <= '0;
            last_data   <= '0;
        end else if (stats_clr) begin
            timeout     <= 1'b0;
            cycle_count <= '0;
            last_addr   <= '0;
            last_data   <= '0;
        end else begin
            if (state == RUN) begin
                cycle_count <= cycle_next;
            end
            if (run_store) begin
                last_addr <= DM_addr;
                last_data <= DM_writeData;
            end
            if (run_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
